tx_bit_scrambler: RTL

- Upstream feeder of the OFDM TX chain.
- Accepts payload bytes over the team's CYC/STB/WE/ACK streaming handshake.
- Scrambles them with the 802.11 scrambler (x^7+x^4+1).
- Serialises each byte into four 2-bit dibits on a matching master port, which drives the QPSK modulator's 2-bit data input.

---
 rtl/tx_bit_scrambler.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/tx_bit_scrambler.sv
// Byte-to-dibit feeder for the OFDM TX chain: 802.11 scrambler (x^7+x^4+1), CYC/STB/WE/ACK on both sides.
// Define TX_SCR_BYPASS_EN to add BYPASS_I (raw bits out, LFSR frozen for that dibit).
module tx_bit_scrambler #(
  parameter logic [6:0] SEED = 7'h7F
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic [7:0] DAT_I,
  input  logic       CYC_I,
  input  logic       STB_I,
  input  logic       WE_I,
  output logic       ACK_O,
  output logic [1:0] DAT_O,
  output logic       CYC_O,
  output logic       STB_O,
  output logic       WE_O,
`ifdef TX_SCR_BYPASS_EN
  input  logic       BYPASS_I,
`endif
  input  logic       ACK_I
);

  // Two scrambler steps at once: returns {state after two shifts, second bit, first bit}.
  function automatic logic [8:0] scr_step2(input logic [6:0] s, input logic [1:0] d);
    logic fb0;
    logic fb1;
    fb0 = s[6] ^ s[3];
    fb1 = s[5] ^ s[2];
    return {s[4:0], fb0, fb1, d[1] ^ fb1, d[0] ^ fb0};
  endfunction

  logic [7:0] byte_q, byte_d;
  logic       full_q, full_d;
  logic [1:0] cnt_q, cnt_d;
  logic [6:0] lfsr_q, lfsr_d;
  logic       frame_q, frame_d;

  logic       in_xfer_s;
  logic       out_xfer_s;
  logic       bypass_s;
  logic [1:0] raw_dibit_s;
  logic [8:0] step_s;

`ifdef TX_SCR_BYPASS_EN
  assign bypass_s = BYPASS_I;
`else
  assign bypass_s = 1'b0;
`endif

  // RST_I gates ACK_O so nothing is acknowledged while reset is held.
  assign in_xfer_s  = RST_I & CYC_I & STB_I & WE_I & (~full_q | ((cnt_q == 2'd3) & ACK_I));
  assign out_xfer_s = full_q & ACK_I;
  assign step_s     = scr_step2(lfsr_q, raw_dibit_s);

  assign ACK_O = in_xfer_s;
  assign CYC_O = frame_q;
  assign STB_O = full_q;
  assign WE_O  = full_q;

  // Select the byte bits belonging to the current dibit position.
  always_comb begin
    case (cnt_q)
      2'd0:    raw_dibit_s = byte_q[1:0];
      2'd1:    raw_dibit_s = byte_q[3:2];
      2'd2:    raw_dibit_s = byte_q[5:4];
      2'd3:    raw_dibit_s = byte_q[7:6];
      default: raw_dibit_s = 2'b00;
    endcase
  end

  // Output dibit, forced to zero when nothing is pending.
  always_comb begin
    if (!full_q) begin
      DAT_O = 2'b00;
    end else if (bypass_s) begin
      DAT_O = raw_dibit_s;
    end else begin
      DAT_O = step_s[1:0];
    end
  end

  // Next-state: drain on output transfer, then a load may override (same-cycle refill).
  always_comb begin
    byte_d  = byte_q;
    full_d  = full_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    frame_d = frame_q;

    if (out_xfer_s) begin
      if (bypass_s) begin
        lfsr_d = lfsr_q;
      end else begin
        lfsr_d = step_s[8:2];
      end
      if (cnt_q == 2'd3) begin
        full_d = 1'b0;
        cnt_d  = 2'd0;
      end else begin
        cnt_d  = cnt_q + 2'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end

    if (in_xfer_s) begin
      byte_d = DAT_I;
      full_d = 1'b1;
      cnt_d  = 2'd0;
      // Frame start: the first dibit of the frame sees the fresh seed.
      if (!frame_q) begin
        lfsr_d  = SEED;
        frame_d = 1'b1;
      end else begin
        frame_d = 1'b1;
      end
    end else if (frame_q && !full_q && !CYC_I) begin
      frame_d = 1'b0;
    end else begin
      frame_d = frame_q;
    end
  end

  // State registers.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      byte_q  <= 8'h00;
      full_q  <= 1'b0;
      cnt_q   <= 2'd0;
      lfsr_q  <= SEED;
      frame_q <= 1'b0;
    end else begin
      byte_q  <= byte_d;
      full_q  <= full_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      frame_q <= frame_d;
    end
  end

endmodule
